// File: rtl/aibcr3_dcc_pkg.sv
// Shared definitions for the DCC delay-chain controller: defaults, FSM states
// and detector-window vote thresholds.
package aibcr3_dcc_pkg;

  localparam int unsigned DEF_CODE_W     = 5;
  localparam int unsigned DEF_SETTLE_CYC = 16;
  localparam int unsigned DEF_FILT_W     = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DECIDE,
    ST_TRK_SETTLE,
    ST_TRK_SAMPLE,
    ST_TRK_DECIDE
  } dcc_state_e;

  // Vote thresholds as a count of dc_hi=1 cycles in a 2**filt_w window
  function automatic int unsigned win_half(input int unsigned filt_w);
    return (2 ** filt_w) / 2;
  endfunction

  function automatic int unsigned win_hi(input int unsigned filt_w);
    return (3 * (2 ** filt_w)) / 4;
  endfunction

  function automatic int unsigned win_lo(input int unsigned filt_w);
    return (2 ** filt_w) / 4;
  endfunction

endpackage

// File: rtl/aibcr3_dcc_therm_dec.sv
// Registered binary-to-thermometer decoder; the code and its thermometer
// image come out of the same register so they always change together.
module aibcr3_dcc_therm_dec
  import aibcr3_dcc_pkg::*;
#(
  parameter int unsigned CODE_W = DEF_CODE_W,
  localparam int unsigned NCELL = 2 ** CODE_W - 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] code_d,
  output logic [CODE_W-1:0] code_q,
  output logic [NCELL-1:0]  bk
);

  logic [NCELL-1:0] bk_d;

  always_comb begin
    bk_d = '0;
    for (int unsigned k = 0; k < NCELL; k++) begin
      bk_d[k] = (k < 32'(code_d));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_q <= '0;
      bk     <= '0;
    end else begin
      code_q <= code_d;
      bk     <= bk_d;
    end
  end

endmodule

// File: rtl/aibcr3_dcc_dlyctrl.sv
// DCC delay-chain controller: SAR search of the delay code from the duty-cycle
// detector, then filtered up/down tracking, driving a registered thermometer bus.
module aibcr3_dcc_dlyctrl
  import aibcr3_dcc_pkg::*;
#(
  parameter int unsigned CODE_W     = DEF_CODE_W,
  parameter int unsigned SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int unsigned FILT_W     = DEF_FILT_W,
  localparam int unsigned NCELL     = 2 ** CODE_W - 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dcc_en,
  input  logic              dcc_freeze,
  input  logic              dc_hi,
  input  logic              code_ovr_en,
  input  logic [CODE_W-1:0] code_ovr,
  output logic [NCELL-1:0]  bk,
  output logic [CODE_W-1:0] dcc_code,
  output logic              dcc_lock,
  output logic              dcc_err
);

  localparam int unsigned WIN    = 2 ** FILT_W;
  localparam int unsigned IDX_W  = (CODE_W > 1) ? $clog2(CODE_W) : 1;
  localparam int unsigned CNT_W  = $clog2((SETTLE_CYC > WIN) ? SETTLE_CYC : WIN) + 1;
  localparam int unsigned ONES_W = FILT_W + 1;

  localparam logic [CODE_W-1:0] CODE_MAX = '1;
  localparam logic [CODE_W-1:0] CODE_MID = CODE_W'(1) << (CODE_W - 1);
  localparam logic [ONES_W-1:0] THR_HALF = ONES_W'(win_half(FILT_W));
  localparam logic [ONES_W-1:0] THR_HI   = ONES_W'(win_hi(FILT_W));
  localparam logic [ONES_W-1:0] THR_LO   = ONES_W'(win_lo(FILT_W));

  dcc_state_e        state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [ONES_W-1:0] ones, ones_n;
  logic [IDX_W-1:0]  idx, idx_n, idx_m1;
  logic              lock_n, err_n;
  logic [CODE_W-1:0] code_n;
  logic              abort;

  assign idx_m1 = idx - IDX_W'(1);
  assign abort  = (state != ST_IDLE) && (!dcc_en || code_ovr_en);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      ones     <= '0;
      idx      <= '0;
      dcc_lock <= 1'b0;
      dcc_err  <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      ones     <= ones_n;
      idx      <= idx_n;
      dcc_lock <= lock_n;
      dcc_err  <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    ones_n  = ones;
    idx_n   = idx;
    lock_n  = dcc_lock;
    err_n   = dcc_err;
    code_n  = dcc_code;
    // Abort wins over every state; an override request lands here first and
    // is applied from IDLE on the following edge.
    if (abort) begin
      state_n = ST_IDLE;
      cnt_n   = '0;
      ones_n  = '0;
      code_n  = '0;
      lock_n  = 1'b0;
      err_n   = 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          lock_n = 1'b0;
          if (code_ovr_en) begin
            code_n = code_ovr;
          end else if (dcc_en) begin
            idx_n   = IDX_W'(CODE_W - 1);
            code_n  = CODE_MID;
            cnt_n   = '0;
            ones_n  = '0;
            err_n   = 1'b0;
            state_n = ST_SETTLE;
          end
        end
        ST_SETTLE, ST_TRK_SETTLE: begin
          ones_n = '0;
          if (cnt == CNT_W'(SETTLE_CYC - 1)) begin
            cnt_n   = '0;
            state_n = (state == ST_SETTLE) ? ST_SAMPLE : ST_TRK_SAMPLE;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        ST_SAMPLE, ST_TRK_SAMPLE: begin
          ones_n = ones + ONES_W'(dc_hi);
          if (cnt == CNT_W'(WIN - 1)) begin
            cnt_n   = '0;
            state_n = (state == ST_SAMPLE) ? ST_DECIDE : ST_TRK_DECIDE;
          end else begin
            cnt_n = cnt + CNT_W'(1);
          end
        end
        ST_DECIDE: begin
          if (!(ones > THR_HALF)) code_n[idx] = 1'b0;
          if (idx != '0) begin
            code_n[idx_m1] = 1'b1;
            idx_n          = idx_m1;
            state_n        = ST_SETTLE;
          end else begin
            lock_n  = 1'b1;
            state_n = ST_TRK_SETTLE;
          end
        end
        ST_TRK_DECIDE: begin
          state_n = ST_TRK_SETTLE;
          if (!dcc_freeze) begin
            if (ones >= THR_HI) begin
              if (dcc_code == CODE_MAX) err_n = 1'b1;
              else code_n = dcc_code + CODE_W'(1);
            end else if (ones <= THR_LO) begin
              if (dcc_code == '0) err_n = 1'b1;
              else code_n = dcc_code - CODE_W'(1);
            end
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  aibcr3_dcc_therm_dec #(
    .CODE_W(CODE_W)
  ) u_therm_dec (
    .clk    (clk),
    .rst    (rst),
    .code_d (code_n),
    .code_q (dcc_code),
    .bk     (bk)
  );

endmodule

// File: tb/tb_aibcr3_dcc_dlyctrl.sv
// Scoreboard bench for aibcr3_dcc_dlyctrl: every dcc_code change is matched
// against a queue of hand-computed (code, lock, err) expectations.
module tb_aibcr3_dcc_dlyctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        dcc_en;
  logic        dcc_freeze;
  logic        dc_hi;
  logic        code_ovr_en;
  logic [4:0]  code_ovr;
  logic [30:0] bk;
  logic [4:0]  dcc_code;
  logic        dcc_lock;
  logic        dcc_err;

  // detector model: 0 -> always low, 1 -> high while code < 19, 2 -> always high
  logic [1:0]  mode;

  typedef struct {
    logic [4:0] code;
    logic       lock;
    logic       err;
  } exp_t;

  exp_t q[$];
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  assign dc_hi = (mode == 2'd1) ? (dcc_code < 5'd19) : (mode == 2'd2);

  aibcr3_dcc_dlyctrl #(
    .CODE_W(5),
    .SETTLE_CYC(16),
    .FILT_W(3)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .dcc_en      (dcc_en),
    .dcc_freeze  (dcc_freeze),
    .dc_hi       (dc_hi),
    .code_ovr_en (code_ovr_en),
    .code_ovr    (code_ovr),
    .bk          (bk),
    .dcc_code    (dcc_code),
    .dcc_lock    (dcc_lock),
    .dcc_err     (dcc_err)
  );

  function automatic logic [30:0] therm(input logic [4:0] c);
    logic [31:0] t;
    t = (32'd1 << c) - 32'd1;
    return t[30:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  task automatic push(input logic [4:0] c, input logic l, input logic e);
    exp_t x;
    x.code = c;
    x.lock = l;
    x.err  = e;
    q.push_back(x);
  endtask

  task automatic wait_lock(output int n);
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1;
      if (dcc_lock) begin
        n = i;
        break;
      end
    end
  endtask

  // Monitor: each code change must match the next queued expectation
  initial begin
    logic [4:0] prev;
    exp_t       e;
    @(negedge clk);
    prev = dcc_code;
    forever begin
      @(negedge clk);
      if (dcc_code !== prev) begin
        if (q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_change: got code %0d expected no change at %0t", dcc_code, $time);
        end else begin
          e = q.pop_front();
          chk("mon_code", 32'(dcc_code), 32'(e.code));
          chk("mon_bk", 32'(bk), 32'(therm(e.code)));
          chk("mon_lock", 32'(dcc_lock), 32'(e.lock));
          chk("mon_err", 32'(dcc_err), 32'(e.err));
        end
        prev = dcc_code;
      end
    end
  end

  initial begin
    int  n;
    bit  held;
    rst         = 1'b1;
    dcc_en      = 1'b0;
    dcc_freeze  = 1'b0;
    code_ovr_en = 1'b0;
    code_ovr    = 5'd0;
    mode        = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_code", 32'(dcc_code), 0);
    chk("rst_bk", 32'(bk), 0);
    chk("rst_lock", 32'(dcc_lock), 0);
    chk("rst_err", 32'(dcc_err), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // SAR convergence towards the 18/19 boundary
    mode = 2'd1;
    push(5'd16, 1'b0, 1'b0);
    push(5'd24, 1'b0, 1'b0);
    push(5'd20, 1'b0, 1'b0);
    push(5'd18, 1'b0, 1'b0);
    push(5'd19, 1'b0, 1'b0);
    push(5'd18, 1'b1, 1'b0);
    dcc_en = 1'b1;
    wait_lock(n);
    chk("lock_latency", 32'(n), 126);
    chk("lock_code", 32'(dcc_code), 18);
    push(5'd19, 1'b1, 1'b0);
    push(5'd18, 1'b1, 1'b0);
    push(5'd19, 1'b1, 1'b0);
    push(5'd18, 1'b1, 1'b0);
    repeat (110) @(posedge clk);
    #1;
    chk("track_code", 32'(dcc_code), 18);
    chk("track_err", 32'(dcc_err), 0);

    // Freeze with a detector demanding more delay
    mode = 2'd2;
    dcc_freeze = 1'b1;
    held = 1'b1;
    repeat (110) begin
      @(posedge clk);
      #1;
      if (dcc_code !== 5'd18) held = 1'b0;
    end
    chk("freeze_hold", 32'(held), 1);
    push(5'd19, 1'b1, 1'b0);
    dcc_freeze = 1'b0;
    n = 0;
    for (int i = 1; i <= 25; i++) begin
      @(posedge clk);
      #1;
      if (dcc_code == 5'd19) begin
        n = i;
        break;
      end
    end
    chk("unfreeze_step", 32'(n != 0), 1);

    // Override while locked: abort edge, then override edge
    push(5'd0, 1'b0, 1'b0);
    push(5'd7, 1'b0, 1'b0);
    code_ovr    = 5'd7;
    code_ovr_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("ovr_bk", 32'(bk), 32'h7F);
    chk("ovr_code", 32'(dcc_code), 7);
    chk("ovr_lock", 32'(dcc_lock), 0);

    // Release override with dcc_en high: SAR restarts, saturates high
    push(5'd16, 1'b0, 1'b0);
    push(5'd24, 1'b0, 1'b0);
    push(5'd28, 1'b0, 1'b0);
    push(5'd30, 1'b0, 1'b0);
    push(5'd31, 1'b0, 1'b0);
    code_ovr_en = 1'b0;
    wait_lock(n);
    chk("sat_lock_seen", 32'(n != 0), 1);
    repeat (30) @(posedge clk);
    #1;
    chk("sat_err", 32'(dcc_err), 1);
    chk("sat_code", 32'(dcc_code), 31);
    chk("sat_bk", 32'(bk), 32'h7FFF_FFFF);
    repeat (50) @(posedge clk);
    #1;
    chk("sat_err_sticky", 32'(dcc_err), 1);

    // Disable from tracking clears everything
    push(5'd0, 1'b0, 1'b0);
    dcc_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("dis_lock", 32'(dcc_lock), 0);
    chk("dis_err", 32'(dcc_err), 0);

    // Abort in the middle of step 3 SAMPLE
    mode = 2'd1;
    push(5'd16, 1'b0, 1'b0);
    push(5'd24, 1'b0, 1'b0);
    push(5'd20, 1'b0, 1'b0);
    dcc_en = 1'b1;
    @(posedge clk);
    repeat (70) @(posedge clk);
    #1;
    chk("abort_pre_code", 32'(dcc_code), 20);
    push(5'd0, 1'b0, 1'b0);
    dcc_en = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_code", 32'(dcc_code), 0);
    chk("abort_bk", 32'(bk), 0);
    chk("abort_lock", 32'(dcc_lock), 0);
    repeat (2) @(posedge clk);
    #1;
    push(5'd16, 1'b0, 1'b0);
    dcc_en = 1'b1;
    @(posedge clk);
    #1;
    chk("restart_code", 32'(dcc_code), 16);

    // Relock, take one tracking step, then async reset between edges
    push(5'd24, 1'b0, 1'b0);
    push(5'd20, 1'b0, 1'b0);
    push(5'd18, 1'b0, 1'b0);
    push(5'd19, 1'b0, 1'b0);
    push(5'd18, 1'b1, 1'b0);
    push(5'd19, 1'b1, 1'b0);
    wait_lock(n);
    chk("relock_seen", 32'(n != 0), 1);
    repeat (30) @(posedge clk);
    #1;
    chk("relock_track", 32'(dcc_code), 19);
    push(5'd0, 1'b0, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_code", 32'(dcc_code), 0);
    chk("arst_bk", 32'(bk), 0);
    chk("arst_lock", 32'(dcc_lock), 0);
    chk("arst_err", 32'(dcc_err), 0);
    dcc_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("queue_empty", 32'(q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
